// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared sizing helpers for the RAM-backed FIFO controller.
package ram_fifo_ctrl_pkg;

    localparam int AF_MARGIN = 2;

    // Occupancy runs 0..DEPTH inclusive, so it needs one bit more than the pointers.
    function automatic int fifo_cnt_w(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: synchronous write, registered read address, combinational read data.
module dual_port_ram #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];
    logic [ADDR_WIDTH-1:0] raddr_q;

    always_ff @(posedge clk) begin
        if (write_en) mem[waddr] <= din;
        raddr_q <= raddr;
    end

    assign dout = mem[raddr_q];

endmodule

// File: rtl/ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around one dual_port_ram.
// Define RAM_FIFO_ERR_FLAG_EN to add sticky overflow/underflow outputs.
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH        = 5,
    parameter int DATA_WIDTH        = 8,
    parameter int ALMOST_FULL_LEVEL = 2**ADDR_WIDTH - AF_MARGIN
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic                              push,
    input  logic [DATA_WIDTH-1:0]             din,
    input  logic                              pop,
    output logic [DATA_WIDTH-1:0]             dout,
    output logic                              empty,
    output logic                              full,
    output logic                              almost_full,
    output logic [fifo_cnt_w(ADDR_WIDTH)-1:0] count
`ifdef RAM_FIFO_ERR_FLAG_EN
    ,
    output logic                              overflow,
    output logic                              underflow
`endif
);

    localparam int CW = fifo_cnt_w(ADDR_WIDTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(2**ADDR_WIDTH);
    localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_LEVEL);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  empty_q, full_q, af_q;
    logic                  push_ok, pop_ok, clr;

    always_comb begin
        clr      = reset | flush;
        push_ok  = push & ~full_q;
        pop_ok   = pop & ~empty_q;
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(push_ok);
        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(pop_ok);
        count_d  = count_q;
        if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
        else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Flags come from the next-state count so they never depend on same-cycle push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == DEPTH_C);
            af_q     <= (count_d >= AF_C);
        end
    end

    // Read address is the next rd_ptr (including the clear to 0), so the RAM's
    // registered address always tracks the head and dout = mem[rd_ptr].
    dual_port_ram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .write_en(push_ok & ~clr),
        .waddr   (wr_ptr_q),
        .din     (din),
        .raddr   (rd_ptr_d),
        .dout    (dout)
    );

    assign empty       = empty_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign count       = count_q;

`ifdef RAM_FIFO_ERR_FLAG_EN
    logic ovf_q, unf_q;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (push && full_q)  ovf_q <= 1'b1;
            if (pop && empty_q)  unf_q <= 1'b1;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`endif

endmodule
